// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared types for the CDB writeback path: functional-unit result payload and
// the registered broadcast slot seen by ROB, RS wakeup and the register file.
package cdb_writeback_arbiter_pkg;

  localparam int CDB   = 5;
  localparam int N_WB  = 2;
  localparam int SRC_W = $clog2(CDB);

  typedef struct packed {
    logic [4:0]  rob_idx;
    logic [5:0]  pd;
    logic [31:0] value;
  } fu_output_t;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] src;
    fu_output_t       data;
  } cdb_slot_t;

  typedef cdb_slot_t cdb_bus_t [N_WB];

endpackage

// File: rtl/cdb_writeback_arbiter_if.sv
// Producer request bus and CDB broadcast bus; slave is the arbiter side.
interface cdb_writeback_arbiter_if #(
  parameter int N_REQ = cdb_writeback_arbiter_pkg::CDB,
  parameter int N_WB  = cdb_writeback_arbiter_pkg::N_WB
);
  import cdb_writeback_arbiter_pkg::fu_output_t;

  logic       [N_REQ-1:0]                     req_valid;
  fu_output_t [N_REQ-1:0]                     req_data;
  logic       [N_REQ-1:0]                     req_ready;
  logic       [N_WB-1:0]                      cdb_valid;
  fu_output_t [N_WB-1:0]                      cdb_data;
  logic       [N_WB-1:0][$clog2(N_REQ)-1:0]  cdb_src;

  modport master (
    output req_valid, req_data,
    input  req_ready, cdb_valid, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, cdb_valid, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_writeback_arbiter_skid_fifo.sv
// Per-producer skid FIFO holding finished results until a CDB slot is free.
module wb_skid_fifo
  import cdb_writeback_arbiter_pkg::fu_output_t;
#(
  parameter int SKID_D = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  fu_output_t din,
  output fu_output_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(SKID_D);

  logic [AW:0] wr_ptr, rd_ptr;
  fu_output_t  mem [SKID_D];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Rotating-priority writeback arbiter: drains up to N_WB producer FIFO heads
// per cycle onto registered CDB broadcast slots.
module cdb_writeback_arbiter #(
  parameter int N_REQ  = cdb_writeback_arbiter_pkg::CDB,
  parameter int N_WB   = cdb_writeback_arbiter_pkg::N_WB,
  parameter int SKID_D = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  cdb_writeback_arbiter_if.slave  bus,
  output logic [31:0]             stall_cnt
);
  import cdb_writeback_arbiter_pkg::fu_output_t;
  import cdb_writeback_arbiter_pkg::cdb_slot_t;
  import cdb_writeback_arbiter_pkg::SRC_W;

  localparam int PTR_W = $clog2(N_REQ);

  logic [N_REQ-1:0] full, empty, push, pop, grant;
  fu_output_t       head [N_REQ];
  logic [PTR_W-1:0] rr_ptr, rr_nxt;
  logic             any_gnt, stall_any;
  int               n_gnt, idx;
  cdb_slot_t        slot_p0 [N_WB];
  cdb_slot_t        slot_p1 [N_WB];

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    wb_skid_fifo #(.SKID_D(SKID_D)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (bus.req_data[i]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Stage p0: scan from rr_ptr and fill slots in discovery order.
  always_comb begin
    grant   = '0;
    any_gnt = 1'b0;
    rr_nxt  = rr_ptr;
    n_gnt   = 0;
    idx     = 0;
    for (int k = 0; k < N_WB; k++) slot_p0[k] = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (!empty[idx] && n_gnt < N_WB) begin
        grant[idx]          = 1'b1;
        slot_p0[n_gnt].valid = 1'b1;
        slot_p0[n_gnt].src   = SRC_W'(idx);
        slot_p0[n_gnt].data  = head[idx];
        n_gnt               = n_gnt + 1;
        rr_nxt              = PTR_W'((idx + 1) % N_REQ);
        any_gnt             = 1'b1;
      end
    end
  end

  // A full FIFO still accepts when its head leaves in the same cycle.
  assign pop           = flush ? '0 : grant;
  assign bus.req_ready = flush ? '1 : (~full | pop);
  assign push          = bus.req_valid & bus.req_ready & ~{N_REQ{flush}};
  assign stall_any     = |(~empty & ~grant);

  // Stage p1: registered broadcast slots, pointer and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < N_WB; k++) slot_p1[k] <= '0;
    end else begin
      if (flush) begin
        for (int k = 0; k < N_WB; k++) slot_p1[k] <= '0;
      end else begin
        slot_p1 <= slot_p0;
        if (any_gnt) rr_ptr <= rr_nxt;
      end
      if (stall_any && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  for (genvar k = 0; k < N_WB; k++) begin : g_out
    assign bus.cdb_valid[k] = slot_p1[k].valid;
    assign bus.cdb_data[k]  = slot_p1[k].data;
    assign bus.cdb_src[k]   = slot_p1[k].src;

    a_slot_popped : assert property (@(posedge clk) disable iff (!rst_n)
      (slot_p0[k].valid && !flush) |-> pop[slot_p0[k].src]);

    for (genvar j = 0; j < k; j++) begin : g_uniq
      a_no_double_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(slot_p0[j].valid && slot_p0[k].valid && slot_p0[j].src == slot_p0[k].src));
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: fixed vector table, directed corner
// sequences, and random traffic against a queue-based reference model.
module tb_cdb_writeback_arbiter;
  import cdb_writeback_arbiter_pkg::*;

  localparam int NR = CDB;
  localparam int NW = N_WB;
  localparam int SD = 2;
  localparam int FW = $bits(fu_output_t);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] stall_cnt;

  cdb_writeback_arbiter_if #(.N_REQ(NR), .N_WB(NW)) bus ();

  cdb_writeback_arbiter #(.N_REQ(NR), .N_WB(NW), .SKID_D(SD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per producer, rotating start index.
  fu_output_t   mq [NR][$];
  int           m_rr;
  longint       m_stall;
  logic [NW-1:0] e_vld;
  int           e_src [NW];
  fu_output_t   e_dat [NW];
  logic [NR-1:0] e_ready;
  logic [NR-1:0] last_ready;
  fu_output_t   last_in [NR];

  typedef struct {
    logic       fl;
    logic [4:0] v;
    logic [4:0] rdy;
    logic [1:0] vld;
    int         s0;
    int         s1;
    int         stall;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit in_list(input int g[$], input int i);
    foreach (g[n]) if (g[n] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mq[i].delete();
    m_rr    = 0;
    m_stall = 0;
    e_vld   = '0;
  endtask

  // Drives one cycle starting just after a rising edge, checks ready before
  // the edge and broadcast outputs just after it.
  task automatic cycle(input logic fl, input logic [NR-1:0] v);
    int g[$];
    logic [63:0] r;
    flush = fl;
    bus.req_valid = v;
    for (int i = 0; i < NR; i++) begin
      r = {$urandom, $urandom};
      bus.req_data[i] = fu_output_t'(r[FW-1:0]);
      last_in[i] = bus.req_data[i];
    end
    for (int off = 0; off < NR; off++) begin
      int id;
      id = (m_rr + off) % NR;
      if (mq[id].size() > 0 && g.size() < NW) g.push_back(id);
    end
    for (int i = 0; i < NR; i++)
      e_ready[i] = fl || (mq[i].size() < SD) || in_list(g, i);
    for (int i = 0; i < NR; i++)
      if (mq[i].size() > 0 && !in_list(g, i)) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
        break;
      end
    #1;
    last_ready = bus.req_ready;
    chk("req_ready", 64'(bus.req_ready), 64'(e_ready));
    e_vld = '0;
    if (fl) begin
      for (int i = 0; i < NR; i++) mq[i].delete();
    end else begin
      foreach (g[k]) begin
        e_vld[k] = 1'b1;
        e_src[k] = g[k];
        e_dat[k] = mq[g[k]].pop_front();
      end
      for (int i = 0; i < NR; i++)
        if (v[i] && e_ready[i]) mq[i].push_back(last_in[i]);
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NR;
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(e_vld));
    for (int k = 0; k < NW; k++)
      if (e_vld[k]) begin
        chk("cdb_src", 64'(bus.cdb_src[k]), 64'(e_src[k]));
        chk("cdb_data", 64'(bus.cdb_data[k]), 64'(e_dat[k]));
      end
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  initial begin
    fu_output_t d0, d1, d2;
    bus.req_valid = '0;
    bus.req_data  = '0;
    model_reset();

    // Reset state while held
    #3;
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
    chk("rst_cdb_data", 64'(bus.cdb_data[0]), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    #19 rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'h1F);
    @(posedge clk);
    #1;

    // All producers valid every cycle from rr_ptr=0, then a flush
    tbl[0] = '{1'b0, 5'h1F, 5'h1F, 2'b00, 0, 0, 0};
    tbl[1] = '{1'b0, 5'h1F, 5'h1F, 2'b11, 0, 1, 1};
    tbl[2] = '{1'b0, 5'h1F, 5'h0F, 2'b11, 2, 3, 2};
    tbl[3] = '{1'b0, 5'h1F, 5'h11, 2'b11, 4, 0, 3};
    tbl[4] = '{1'b0, 5'h1F, 5'h06, 2'b11, 1, 2, 4};
    tbl[5] = '{1'b0, 5'h1F, 5'h18, 2'b11, 3, 4, 5};
    tbl[6] = '{1'b0, 5'h1F, 5'h03, 2'b11, 0, 1, 6};
    tbl[7] = '{1'b1, 5'h1F, 5'h1F, 2'b00, 0, 0, 7};
    tbl[8] = '{1'b0, 5'h1F, 5'h1F, 2'b00, 0, 0, 7};
    tbl[9] = '{1'b0, 5'h1F, 5'h1F, 2'b11, 2, 3, 8};
    for (int j = 0; j < 10; j++) begin
      cycle(tbl[j].fl, tbl[j].v);
      chk("tbl_ready", 64'(last_ready), 64'(tbl[j].rdy));
      chk("tbl_valid", 64'(bus.cdb_valid), 64'(tbl[j].vld));
      if (tbl[j].vld[0]) chk("tbl_src0", 64'(bus.cdb_src[0]), 64'(tbl[j].s0));
      if (tbl[j].vld[1]) chk("tbl_src1", 64'(bus.cdb_src[1]), 64'(tbl[j].s1));
      chk("tbl_stall", 64'(stall_cnt), 64'(tbl[j].stall));
    end
    cycle(1'b1, '0);

    // Async reset mid-traffic with three FIFOs loaded
    cycle(1'b0, 5'h07);
    cycle(1'b0, 5'h07);
    chk("pre_rst_valid", 64'(bus.cdb_valid), 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("async_rst_stall", 64'(stall_cnt), 64'd0);
    model_reset();
    bus.req_valid = '0;
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'h1F);
    @(posedge clk);
    #1;
    cycle(1'b0, '0);
    chk("rst_lost_valid", 64'(bus.cdb_valid), 64'd0);

    // Single push to empty FIFO 1: one-cycle latency, no bypass
    cycle(1'b0, 5'h02);
    d0 = last_in[1];
    chk("single_no_bypass", 64'(bus.cdb_valid), 64'd0);
    cycle(1'b0, '0);
    chk("single_valid", 64'(bus.cdb_valid), 64'h1);
    chk("single_src", 64'(bus.cdb_src[0]), 64'd1);
    chk("single_data", 64'(bus.cdb_data[0]), 64'(d0));

    // LSQ back-to-back: one broadcast per cycle, order kept, never stalls
    cycle(1'b0, 5'h10); d0 = last_in[4];
    chk("lsq_ready0", 64'(last_ready[4]), 64'd1);
    cycle(1'b0, 5'h10); d1 = last_in[4];
    chk("lsq_ready1", 64'(last_ready[4]), 64'd1);
    chk("lsq_data0", 64'(bus.cdb_data[0]), 64'(d0));
    cycle(1'b0, 5'h10); d2 = last_in[4];
    chk("lsq_ready2", 64'(last_ready[4]), 64'd1);
    chk("lsq_data1", 64'(bus.cdb_data[0]), 64'(d1));
    cycle(1'b0, '0);
    chk("lsq_data2", 64'(bus.cdb_data[0]), 64'(d2));
    chk("lsq_src", 64'(bus.cdb_src[0]), 64'd4);
    cycle(1'b0, '0);
    chk("lsq_drained", 64'(bus.cdb_valid), 64'd0);

    // Flush with buffered results and pushes in the flush cycle
    cycle(1'b0, 5'h1F);
    cycle(1'b0, 5'h1F);
    cycle(1'b1, 5'h03);
    chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, '0);
      chk("flush_no_stale", 64'(bus.cdb_valid), 64'd0);
    end

    // Random traffic with occasional flush
    for (int c = 0; c < 600; c++)
      cycle(($urandom_range(0, 31) == 0), NR'($urandom));

    flush = 1'b0;
    bus.req_valid = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
